// File: rtl/mem_serial_sched.sv
// rtl/mem_serial_sched.sv - word fetch and LSB-first bit serialiser sequencer for a memory -> mux datapath
module mem_serial_sched #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = (DATA_W > 1) ? $clog2(DATA_W) : 1,
  localparam int WL_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [WL_W-1:0]   num_words,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [SEL_W-1:0]  sel,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   word_reg_q, word_reg_d;
  logic [WL_W-1:0]     words_left_q, words_left_d;
  logic                bit_valid_q, bit_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and datapath updates; abort overrides any same-cycle handshake.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    sel_d        = sel_q;
    word_reg_d   = word_reg_q;
    words_left_d = words_left_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mem_addr_d   = start_addr;
            words_left_d = num_words;
            state_d      = (num_words == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          word_reg_d = mem_rdata;
          sel_d      = '0;
          state_d    = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_ready) begin
            if (sel_q != SEL_W'(DATA_W - 1)) begin
              sel_d = sel_q + SEL_W'(1);
            end else if (words_left_q == WL_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              words_left_d = words_left_q - WL_W'(1);
              mem_addr_d   = mem_addr_q + ADDR_W'(1);
              state_d      = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    bit_valid_d = (state_d == ST_SHIFT);
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
    done_d      = (state_d == ST_DONE);
  end

  // All sequencer state; clear drops any transfer in flight immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      sel_q        <= '0;
      word_reg_q   <= '0;
      words_left_q <= '0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      sel_q        <= sel_d;
      word_reg_q   <= word_reg_d;
      words_left_q <= words_left_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign sel       = sel_q;
  assign bit_out   = word_reg_q[sel_q];
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_serial_sched.sv
// tb/tb_mem_serial_sched.sv - self-checking bench for mem_serial_sched
module tb_mem_serial_sched;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] start_addr = '0;
  logic [4:0] num_words = '0;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [2:0] sel;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic       busy;
  logic       done;

  mem_serial_sched dut (
    .clock(clock), .clear(clear), .start(start), .abort(abort),
    .start_addr(start_addr), .num_words(num_words), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .sel(sel), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .busy(busy), .done(done)
  );

  assign mem_rdata = mem_addr[0] ? 8'hCC : 8'hAA;

  always #5 clock = ~clock;

  localparam int K_GAP  = 0;
  localparam int K_BIT  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    int         bidx;
    logic       b;
  } item_t;

  item_t      q[$];
  int         checks = 0;
  int         errors = 0;
  int         sample = 0;
  int         start_sample = 0;
  int         done_sample = 0;
  int         done_count = 0;
  int         valid_seen = 0;
  int         busy_seen = 0;
  int         bit_cnt = 0;
  logic [63:0] bit_log = '0;
  logic [3:0] idle_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  // Expand an accepted transfer into the cycle-by-cycle sequence it must produce.
  task automatic build(input logic [3:0] sa, input int n);
    item_t it;
    logic [3:0] a;
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      a = 4'(int'(sa) + i);
      w = a[0] ? 8'hCC : 8'hAA;
      it.kind = K_GAP; it.addr = a; it.bidx = 0; it.b = 1'b0;
      q.push_back(it);
      for (int j = 0; j < 8; j++) begin
        it.kind = K_BIT; it.addr = a; it.bidx = j; it.b = w[j];
        q.push_back(it);
      end
    end
    it.kind = K_DONE;
    it.addr = (n == 0) ? sa : 4'(int'(sa) + n - 1);
    it.bidx = 0; it.b = 1'b0;
    q.push_back(it);
  endtask

  // Compare process: check outputs against the expected sequence, then advance it.
  always @(negedge clock) begin
    item_t f;
    bit was_idle;
    sample++;
    if (bit_valid) valid_seen++;
    if (busy) busy_seen++;
    if (!clear) begin
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_flags", {29'd0, bit_valid, busy, done}, 32'd0);
      chk("rst_bit", 32'(bit_out), 32'd0);
      q.delete();
      idle_addr = '0;
    end else begin
      was_idle = (q.size() == 0);
      if (was_idle) begin
        chk("idle_flags", {29'd0, bit_valid, busy, done}, 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'(idle_addr));
      end else begin
        f = q[0];
        chk("mem_addr", 32'(mem_addr), 32'(f.addr));
        case (f.kind)
          K_GAP:  chk("fetch_flags", {29'd0, bit_valid, busy, done}, 32'b010);
          K_DONE: chk("done_flags", {29'd0, bit_valid, busy, done}, 32'b001);
          default: begin
            chk("shift_flags", {29'd0, bit_valid, busy, done}, 32'b110);
            chk("sel", 32'(sel), 32'(f.bidx));
            chk("bit_out", 32'(bit_out), 32'(f.b));
          end
        endcase
        if (abort) begin
          idle_addr = f.addr;
          q.delete();
        end else if (f.kind == K_GAP) begin
          void'(q.pop_front());
        end else if (f.kind == K_DONE) begin
          void'(q.pop_front());
          done_count++;
          done_sample = sample;
          idle_addr = f.addr;
        end else if (bit_ready) begin
          void'(q.pop_front());
          bit_log[bit_cnt] = f.b;
          bit_cnt++;
        end
      end
      if (was_idle && start) begin
        start_sample = sample;
        build(start_addr, int'(num_words));
      end
    end
  end

  task automatic do_start(input logic [3:0] sa, input logic [4:0] n);
    @(posedge clock); #1;
    start = 1'b1; start_addr = sa; num_words = n;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(nm);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_sel(input logic [2:0] s, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (bit_valid && sel == s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(nm);
  endtask

  task automatic reset_logs();
    bit_cnt = 0; bit_log = '0; done_count = 0; valid_seen = 0; busy_seen = 0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 clear = 1'b1;
    repeat (2) @(posedge clock);

    // 1: two words from address 0
    reset_logs();
    do_start(4'd0, 5'd2);
    wait_idle("t1_wait");
    chk("t1_bits", 32'(bit_log[15:0]), 32'h0000CCAA);
    chk("t1_nbits", 32'(bit_cnt), 32'd16);
    chk("t1_done_lat", 32'(done_sample - start_sample), 32'd19);
    chk("t1_done_cnt", 32'(done_count), 32'd1);

    // 2: consumer stalls for three cycles at sel=3
    reset_logs();
    do_start(4'd0, 5'd2);
    wait_sel(3'd3, "t2_sel3");
    bit_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("t2_hold_sel", 32'(sel), 32'd3);
      chk("t2_hold_bit", 32'(bit_out), 32'd1);
      @(posedge clock); #1;
    end
    bit_ready = 1'b1;
    wait_idle("t2_wait");
    chk("t2_bits", 32'(bit_log[15:0]), 32'h0000CCAA);
    chk("t2_done_lat", 32'(done_sample - start_sample), 32'd22);

    // 3: zero-length transfer
    reset_logs();
    do_start(4'd7, 5'd0);
    wait_idle("t3_wait");
    chk("t3_done_lat", 32'(done_sample - start_sample), 32'd1);
    chk("t3_valid_seen", 32'(valid_seen), 32'd0);
    chk("t3_busy_seen", 32'(busy_seen), 32'd0);
    chk("t3_done_cnt", 32'(done_count), 32'd1);

    // 4: address wrap 15 -> 0
    reset_logs();
    do_start(4'd15, 5'd2);
    wait_idle("t4_wait");
    chk("t4_bits", 32'(bit_log[15:0]), 32'h0000AACC);
    chk("t4_last_addr", 32'(mem_addr), 32'd0);

    // 5: abort at sel=5 of word 0, then restart
    reset_logs();
    do_start(4'd0, 5'd2);
    wait_sel(3'd5, "t5_sel5");
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("t5_abort_valid", 32'(bit_valid), 32'd0);
    chk("t5_abort_sel", 32'(sel), 32'd5);
    chk("t5_abort_done", 32'(done_count), 32'd0);
    bit_cnt = 0; bit_log = '0;
    do_start(4'd1, 5'd1);
    wait_idle("t5_wait");
    chk("t5_restart_bits", 32'(bit_log[7:0]), 32'h000000CC);
    chk("t5_restart_lat", 32'(done_sample - start_sample), 32'd10);
    chk("t5_done_cnt", 32'(done_count), 32'd1);

    // 6: asynchronous clear mid-shift, then ignored starts while busy
    reset_logs();
    do_start(4'd0, 5'd2);
    wait_sel(3'd2, "t6_sel2");
    #2 clear = 1'b0;
    #1;
    chk("t6_async_flags", {29'd0, bit_valid, busy, done}, 32'd0);
    chk("t6_async_addr", 32'(mem_addr), 32'd0);
    chk("t6_async_sel", 32'(sel), 32'd0);
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    reset_logs();
    do_start(4'd3, 5'd2);
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(posedge clock);
      #1 start = 1'b1; start_addr = 4'd9; num_words = 5'd1;
      @(posedge clock); #1 start = 1'b0;
    end
    wait_idle("t6_wait");
    chk("t6_done_cnt", 32'(done_count), 32'd1);
    chk("t6_bits", 32'(bit_log[15:0]), 32'h0000AACC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
